adder16_operand_sequencer: RTL and testbench
============================================

Name: adder16_operand_sequencer

Overview:
Sequential front/back stage wrapped around the combinational sixteenbit_adder. It accepts two 16-bit operands one word at a time over a valid/ready stream and drives them onto the adder's a/b inputs. It registers the adder's f/ovf result and presents it on an output valid/ready stream. It also keeps a saturating count of overflowed additions, for board-level display.

Parameters:
WIDTH, 16, operand/result width; must match the adder instance.
CNT_W, 8, width of the overflow event counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_data  in  WIDTH  operand word.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  block can accept an operand this cycle.
add_a  out  WIDTH  to adder input a (registered).
add_b  out  WIDTH  to adder input b (registered).
add_f  in  WIDTH  from adder sum output f.
add_ovf  in  1  from adder signed-overflow output ovf.
res_f  out  WIDTH  registered sum.
res_ovf  out  1  registered overflow flag for res_f.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts result.
ovf_count  out  CNT_W  number of results captured with ovf=1, saturating.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst), sampled on the rising edge of clk.
- On reset: state=LOAD_A, add_a=0, add_b=0, res_f=0, res_ovf=0, res_valid=0, ovf_count=0. in_ready is 1 on the first cycle after reset.
- Handshakes:
  - An input transfer occurs on a rising edge where in_valid and in_ready are both 1.
  - An output transfer occurs where res_valid and res_ready are both 1.
  - in_data must be held stable while in_valid=1 and in_ready=0. in_valid is ignored when in_ready=0.
- State machine (4 states):
  - LOAD_A: in_ready=1. On transfer: add_a<=in_data, go to LOAD_B. Otherwise stay.
  - LOAD_B: in_ready=1. On transfer: add_b<=in_data, go to ADD. Otherwise stay; add_a is held.
  - ADD: in_ready=0. Unconditionally res_f<=add_f, res_ovf<=add_ovf, res_valid<=1. If add_ovf=1 and ovf_count is not all-ones, ovf_count<=ovf_count+1. Go to HOLD.
  - HOLD: in_ready=0, res_valid=1. res_f and res_ovf are held stable. On output transfer: res_valid<=0, go to LOAD_A. Otherwise stay indefinitely.
- Latency: B accepted at edge N; adder settles during cycle N+1 (ADD); res_valid high from edge N+1 onward. In the best case a new A can be accepted on the cycle after the output transfer. Maximum throughput is one addition per 4 cycles.
- add_a and add_b keep their last loaded values until overwritten. res_f and res_ovf keep the last result after res_valid drops.
- Arithmetic is performed entirely by the external adder; this block does not recompute or check it. f is the WIDTH-bit wrap-around sum. ovf is signed two's-complement overflow.
- ovf_count saturates at 2^CNT_W-1 and never wraps. It is cleared only by rst.
- in_ready is a pure function of state. res_valid is a register. There are no combinational paths from res_ready or in_valid to any output.
- A simultaneous in_valid while in HOLD has no effect; the word is not consumed.
- Reset asserted in any state (mid-load, ADD or HOLD) discards partial operands and any pending result. All outputs take reset values on that edge, including ovf_count.

Test Plan:
- Basic add: feed 0x0025 then 0x0045, res_ready=1 -> res_valid one edge after ADD, res_f=0x006A, res_ovf=0, ovf_count=0.
- Positive overflow: 0x7FFF, 0x7FFF -> res_f=0xFFFE, res_ovf=1, ovf_count=1. Then 0x9D00, 0x9E00 -> res_f=0x3B00, res_ovf=1, ovf_count=2. Then 0x8A10, 0x7110 -> res_f=0xFB20, res_ovf=0, ovf_count stays 2.
- Back-pressure: 0xA415, 0xA555 with res_ready=0 for 10 cycles -> res_valid held 1, res_f=0x496A and res_ovf=1 stable, in_ready=0, in_valid pulses ignored. Raise res_ready -> one transfer, then in_ready=1.
- Input stalls: gaps of 3 cycles with in_valid=0 between words, and in_valid=1 while in HOLD -> no extra operand consumed. add_a/add_b equal the accepted words; the next sum uses the next two accepted words.
- Saturation (CNT_W=2 override): five additions of 0xFFFF+0x8000 (ovf=1) -> ovf_count sequence 1,2,3,3,3.
- Reset mid-operation: load A=0x1234, assert rst in LOAD_B; and separately assert rst in HOLD -> all outputs zero, state LOAD_A. Next pair 0x0001, 0x0002 -> res_f=0x0003.

Source files
------------

// File: rtl/adder16_operand_sequencer_if.sv
// rtl/adder16_operand_sequencer_if.sv - operand input stream and result output stream bundle
interface adder16_operand_sequencer_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res_f;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_f, res_ovf, res_valid
  );

  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_f, res_ovf, res_valid
  );
endinterface

// File: rtl/adder16_operand_sequencer.sv
// rtl/adder16_operand_sequencer.sv - loads two operands into an external adder and registers its result
module adder16_operand_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  adder16_operand_sequencer_if.slave bus,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  input  logic [WIDTH-1:0]    add_f,
  input  logic                add_ovf,
  output logic [CNT_W-1:0]    ovf_count
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ADD    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] res_f;
  logic             res_ovf;
  logic             res_valid;

  // Ready decodes state only, so no input-to-output combinational path exists.
  assign bus.in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign bus.res_f     = res_f;
  assign bus.res_ovf   = res_ovf;
  assign bus.res_valid = res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      add_a     <= '0;
      add_b     <= '0;
      res_f     <= '0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
      ovf_count <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (bus.in_valid) begin
            add_a <= bus.in_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            add_b <= bus.in_data;
            state <= ADD;
          end
        end
        ADD: begin
          // The adder has had a full cycle to settle on the registered operands.
          res_f     <= add_f;
          res_ovf   <= add_ovf;
          res_valid <= 1'b1;
          if (add_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
          end
          state <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_adder16_operand_sequencer.sv
// tb/tb_adder16_operand_sequencer.sv - randomized and directed check against a behavioural model
module tb_adder16_operand_sequencer;
  logic clk;
  logic rst;

  adder16_operand_sequencer_if #(.WIDTH(16)) bus ();
  adder16_operand_sequencer_if #(.WIDTH(16)) bus2 ();

  logic [15:0] add_a, add_b, add_f;
  logic        add_ovf;
  logic [7:0]  ovf_count;
  logic [15:0] add_a2, add_b2, add_f2;
  logic        add_ovf2;
  logic [1:0]  ovf_count2;

  // Stand-ins for the external combinational adder.
  assign add_f    = add_a + add_b;
  assign add_ovf  = (add_a[15] == add_b[15]) && (add_f[15] != add_a[15]);
  assign add_f2   = add_a2 + add_b2;
  assign add_ovf2 = (add_a2[15] == add_b2[15]) && (add_f2[15] != add_a2[15]);

  assign bus2.in_data   = bus.in_data;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.res_ready = bus.res_ready;

  adder16_operand_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .add_a(add_a), .add_b(add_b), .add_f(add_f), .add_ovf(add_ovf),
    .ovf_count(ovf_count)
  );

  adder16_operand_sequencer #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .add_a(add_a2), .add_b(add_b2), .add_f(add_f2), .add_ovf(add_ovf2),
    .ovf_count(ovf_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: operand pairing, one settle cycle, then a held result.
  logic [15:0] m_a = '0, m_b = '0, m_res_f = '0;
  logic        m_res_ovf = 1'b0;
  logic        m_got_a = 1'b0, m_comp = 1'b0, m_have = 1'b0;
  int          m_cnt = 0, m_cnt2 = 0;
  logic        last_acc = 1'b0;
  logic        rand_rst_en = 1'b0;

  function automatic logic m_ready();
    return !m_comp && !m_have;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int sa, sb, ss;
    if (rst) begin
      m_a = '0; m_b = '0; m_res_f = '0; m_res_ovf = 1'b0;
      m_got_a = 1'b0; m_comp = 1'b0; m_have = 1'b0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (m_comp) begin
      sa = int'($signed(m_a));
      sb = int'($signed(m_b));
      ss = sa + sb;
      m_res_f   = 16'(int'(m_a) + int'(m_b));
      m_res_ovf = (ss > 32767) || (ss < -32768);
      if (m_res_ovf && m_cnt < 255) m_cnt++;
      if (m_res_ovf && m_cnt2 < 3) m_cnt2++;
      m_comp = 1'b0;
      m_have = 1'b1;
    end else if (m_have) begin
      if (bus.res_ready) m_have = 1'b0;
    end else if (bus.in_valid) begin
      if (!m_got_a) begin
        m_a = bus.in_data; m_got_a = 1'b1;
      end else begin
        m_b = bus.in_data; m_got_a = 1'b0; m_comp = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("in_ready",   32'(bus.in_ready),   32'(m_ready()));
    check("add_a",      32'(add_a),          32'(m_a));
    check("add_b",      32'(add_b),          32'(m_b));
    check("res_valid",  32'(bus.res_valid),  32'(m_have));
    check("res_f",      32'(bus.res_f),      32'(m_res_f));
    check("res_ovf",    32'(bus.res_ovf),    32'(m_res_ovf));
    check("ovf_count",  32'(ovf_count),      32'(m_cnt));
    check("ovf_count2", 32'(ovf_count2),     32'(m_cnt2));
    check("in_ready2",  32'(bus2.in_ready),  32'(m_ready()));
    check("res_f2",     32'(bus2.res_f),     32'(m_res_f));
  endtask

  task automatic tick(input logic iv, input logic [15:0] d, input logic rr, input logic r);
    logic r_eff;
    r_eff = r || (rand_rst_en && ($urandom_range(59) == 0));
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.res_ready = rr;
    rst           = r_eff;
    last_acc      = iv && m_ready() && !r_eff;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic put_word(input logic [15:0] d, input int gap);
    int n;
    repeat (gap) tick(1'b0, 16'($urandom), 1'($urandom), 1'b0);
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      tick(1'b1, d, 1'b1, 1'b0);
      n++;
    end
    n_cmp++;
    if (!last_acc) begin
      n_bad++;
      $display("FAIL put_word_timeout: word 0x%0h not accepted in 20 cycles", d);
    end
  endtask

  task automatic wait_result(input int hold);
    int n;
    repeat (hold) tick(1'($urandom), 16'($urandom), 1'b0, 1'b0);
    n = 0;
    while ((m_comp || m_have) && n < 20) begin
      tick(1'($urandom), 16'($urandom), 1'b1, 1'b0);
      n++;
    end
    n_cmp++;
    if (m_comp || m_have) begin
      n_bad++;
      $display("FAIL result_timeout: result not drained in 20 cycles");
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input int gap, input int hold);
    put_word(a, gap);
    put_word(b, gap);
    wait_result(hold);
  endtask

  initial begin
    int sat_exp [5];
    logic [15:0] ra, rb;
    sat_exp = '{1, 2, 3, 3, 3};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);

    op(16'h0025, 16'h0045, 0, 0);
    check("basic_res_f", 32'(bus.res_f), 32'h006A);
    check("basic_ovf", 32'(bus.res_ovf), 32'd0);

    op(16'h7FFF, 16'h7FFF, 0, 0);
    check("pos_ovf_res_f", 32'(bus.res_f), 32'hFFFE);
    check("pos_ovf_cnt", 32'(ovf_count), 32'd1);
    op(16'h9D00, 16'h9E00, 0, 0);
    check("neg_ovf_res_f", 32'(bus.res_f), 32'h3B00);
    check("neg_ovf_cnt", 32'(ovf_count), 32'd2);
    op(16'h8A10, 16'h7110, 0, 0);
    check("no_ovf_res_f", 32'(bus.res_f), 32'hFB20);
    check("no_ovf_cnt", 32'(ovf_count), 32'd2);

    op(16'hA415, 16'hA555, 0, 10);
    check("bp_res_f", 32'(bus.res_f), 32'h496A);
    check("bp_res_ovf", 32'(bus.res_ovf), 32'd1);
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);

    op(16'h1000, 16'h0234, 3, 4);
    check("stall_add_a", 32'(add_a), 32'h1000);
    check("stall_res_f", 32'(bus.res_f), 32'h1234);

    tick(1'b0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      op(16'hFFFF, 16'h8000, 0, 0);
      check("sat_count2", 32'(ovf_count2), 32'(sat_exp[k]));
    end

    put_word(16'h1234, 0);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("rst_loadb_add_a", 32'(add_a), 32'd0);
    check("rst_loadb_count", 32'(ovf_count), 32'd0);
    put_word(16'h1111, 0);
    put_word(16'h2222, 0);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    check("hold_res_f", 32'(bus.res_f), 32'h3333);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("rst_hold_res_f", 32'(bus.res_f), 32'd0);
    check("rst_hold_res_valid", 32'(bus.res_valid), 32'd0);
    op(16'h0001, 16'h0002, 0, 0);
    check("after_rst_res_f", 32'(bus.res_f), 32'h0003);

    rand_rst_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(3))
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'h7FFF - 16'($urandom_range(3)); rb = 16'($urandom_range(3)); end
        2: begin ra = 16'h8000 + 16'($urandom_range(3)); rb = 16'hFFFF - 16'($urandom_range(3)); end
        default: begin ra = 16'($urandom_range(255)); rb = 16'($urandom_range(255)); end
      endcase
      op(ra, rb, $urandom_range(3), $urandom_range(3));
    end
    rand_rst_en = 1'b0;
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
